load_aligner: RTL and testbench

Load-side counterpart of the store-data shifter in the MEM stage. It accepts one load at a time from the pipeline, issues a word-aligned read to data memory, and waits for the read response. It then extracts, sign/zero-extends or merges (LWL/LWR) the returned word into the value written back to `rd`. It also flags misaligned LH/LHU/LW/LWU, and supports a pipeline flush that cancels or drains an in-flight read.

---
 rtl/load_aligner.sv | 155 +++++++++++++++
 tb/tb_load_aligner.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_aligner.sv
`default_nettype none
// ============================================================================
// load_aligner : MEM-stage load path - word read, extract/extend/merge, align check
// Revision 1.0
// ============================================================================
module load_aligner (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [2:0]  req_load_sel,
   input  logic [31:0] req_rt_data,
   input  logic [4:0]  req_rd,
   output logic        mem_rd_en,
   output logic [31:0] mem_addr,
   input  logic        mem_rd_valid,
   input  logic [31:0] mem_rd_data,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic [4:0]  resp_rd,
   output logic        addr_err,
   output logic [31:0] bad_vaddr
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t      state_q;
   logic [1:0]  addr_lo_q;
   logic [2:0]  sel_q;
   logic [31:0] rt_q;
   logic [4:0]  rd_q;
   logic [31:0] mem_addr_q;
   logic        resp_valid_q;
   logic [31:0] resp_data_q;
   logic [4:0]  resp_rd_q;
   logic        addr_err_q;
   logic [31:0] bad_vaddr_q;

   logic        misaligned;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] resp_data_d;

   assign req_ready  = rst_n && (state_q == IDLE) && !flush;
   // A flush in ISSUE suppresses the strobe in the same cycle, so it cannot be registered.
   assign mem_rd_en  = rst_n && (state_q == ISSUE) && !flush;
   assign mem_addr   = mem_addr_q;
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign resp_rd    = resp_rd_q;
   assign addr_err   = addr_err_q;
   assign bad_vaddr  = bad_vaddr_q;

   always_comb begin
      misaligned = 1'b0;
      case (req_load_sel)
         3'd2, 3'd3: misaligned = req_addr[0];
         3'd4, 3'd7: misaligned = (req_addr[1:0] != 2'b00);
         default:    misaligned = 1'b0;
      endcase
   end

   always_comb begin
      byte_sel    = 8'(mem_rd_data >> {addr_lo_q, 3'b000});
      half_sel    = addr_lo_q[1] ? mem_rd_data[31:16] : mem_rd_data[15:0];
      resp_data_d = mem_rd_data;
      case (sel_q)
         3'd0: resp_data_d = {{24{byte_sel[7]}}, byte_sel};
         3'd1: resp_data_d = {24'h000000, byte_sel};
         3'd2: resp_data_d = {{16{half_sel[15]}}, half_sel};
         3'd3: resp_data_d = {16'h0000, half_sel};
         3'd5: begin
            case (addr_lo_q)
               2'd0: resp_data_d = mem_rd_data;
               2'd1: resp_data_d = {mem_rd_data[23:0], rt_q[7:0]};
               2'd2: resp_data_d = {mem_rd_data[15:0], rt_q[15:0]};
               2'd3: resp_data_d = {mem_rd_data[7:0],  rt_q[23:0]};
               default: resp_data_d = mem_rd_data;
            endcase
         end
         3'd6: begin
            case (addr_lo_q)
               2'd3: resp_data_d = mem_rd_data;
               2'd2: resp_data_d = {rt_q[31:24], mem_rd_data[31:8]};
               2'd1: resp_data_d = {rt_q[31:16], mem_rd_data[31:16]};
               2'd0: resp_data_d = {rt_q[31:8],  mem_rd_data[31:24]};
               default: resp_data_d = mem_rd_data;
            endcase
         end
         default: resp_data_d = mem_rd_data;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         addr_lo_q    <= 2'b00;
         sel_q        <= 3'd0;
         rt_q         <= 32'h0;
         rd_q         <= 5'd0;
         mem_addr_q   <= 32'h0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= 32'h0;
         resp_rd_q    <= 5'd0;
         addr_err_q   <= 1'b0;
         bad_vaddr_q  <= 32'h0;
      end else begin
         resp_valid_q <= 1'b0;
         addr_err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_valid && req_ready) begin
                  addr_lo_q <= req_addr[1:0];
                  sel_q     <= req_load_sel;
                  rt_q      <= req_rt_data;
                  rd_q      <= req_rd;
                  if (misaligned) begin
                     addr_err_q  <= 1'b1;
                     bad_vaddr_q <= req_addr;
                  end else begin
                     mem_addr_q <= {req_addr[31:2], 2'b00};
                     state_q    <= ISSUE;
                  end
               end
            end
            ISSUE: state_q <= flush ? IDLE : WAIT;
            WAIT: begin
               if (mem_rd_valid) begin
                  if (!flush) begin
                     resp_valid_q <= 1'b1;
                     resp_data_q  <= resp_data_d;
                     resp_rd_q    <= rd_q;
                  end
                  state_q <= IDLE;
               end else if (flush) begin
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (mem_rd_valid) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_load_aligner.sv
`default_nettype none
// ============================================================================
// tb_load_aligner : directed loads checked every cycle against a timeline model
// Revision 1.0
// ============================================================================
module tb_load_aligner;

   localparam int MAXC = 4096;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [2:0]  req_load_sel;
   logic [31:0] req_rt_data;
   logic [4:0]  req_rd;
   logic        mem_rd_en;
   logic [31:0] mem_addr;
   logic        mem_rd_valid;
   logic [31:0] mem_rd_data;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic [4:0]  resp_rd;
   logic        addr_err;
   logic [31:0] bad_vaddr;

   load_aligner dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_addr     (req_addr),
      .req_load_sel (req_load_sel),
      .req_rt_data  (req_rt_data),
      .req_rd       (req_rd),
      .mem_rd_en    (mem_rd_en),
      .mem_addr     (mem_addr),
      .mem_rd_valid (mem_rd_valid),
      .mem_rd_data  (mem_rd_data),
      .resp_valid   (resp_valid),
      .resp_data    (resp_data),
      .resp_rd      (resp_rd),
      .addr_err     (addr_err),
      .bad_vaddr    (bad_vaddr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int  total = 0;
   int  bad   = 0;
   bit  done  = 0;

   // Expected per-cycle outputs, filled in from the timing rules by the stimulus tasks.
   bit          exp_ready [MAXC];
   bit          exp_rd_en [MAXC];
   logic [31:0] exp_addr  [MAXC];
   bit          exp_rv    [MAXC];
   logic [31:0] exp_rdata [MAXC];
   logic [4:0]  exp_rrd   [MAXC];
   bit          exp_err   [MAXC];
   logic [31:0] exp_bad   [MAXC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [31:0] model_load(input logic [2:0] sel, input logic [1:0] a,
                                              input logic [31:0] m, input logic [31:0] r);
      logic [31:0] res;
      logic [7:0]  mb [4];
      logic [7:0]  rb [4];
      int          ai;
      ai = int'(a);
      for (int j = 0; j < 4; j++) begin
         mb[j] = m[8*j +: 8];
         rb[j] = r[8*j +: 8];
      end
      res = m;
      case (sel)
         3'd0, 3'd1: begin
            res = {24'h0, mb[ai]};
            if (sel == 3'd0 && mb[ai][7]) res = res | 32'hFFFFFF00;
         end
         3'd2, 3'd3: begin
            res = (ai >= 2) ? (m >> 16) : (m & 32'h0000FFFF);
            if (sel == 3'd2 && res[15]) res = res | 32'hFFFF0000;
         end
         3'd5: for (int j = 0; j < 4; j++) res[8*j +: 8] = (j >= ai) ? mb[j-ai] : rb[j];
         3'd6: for (int j = 0; j < 4; j++) res[8*j +: 8] = (j <= ai) ? mb[j+3-ai] : rb[j];
         default: res = m;
      endcase
      return res;
   endfunction

   function automatic bit model_mis(input logic [31:0] addr, input logic [2:0] sel);
      if (sel == 3'd2 || sel == 3'd3) return addr[0];
      if (sel == 3'd4 || sel == 3'd7) return addr[1:0] != 2'b00;
      return 1'b0;
   endfunction

   always @(negedge clk) begin
      if (cyc >= 1 && cyc < MAXC && !done) begin
         chk("req_ready", 32'(req_ready), 32'(exp_ready[cyc]));
         chk("mem_rd_en", 32'(mem_rd_en), 32'(exp_rd_en[cyc]));
         if (exp_rd_en[cyc]) chk("mem_addr", mem_addr, exp_addr[cyc]);
         chk("resp_valid", 32'(resp_valid), 32'(exp_rv[cyc]));
         if (exp_rv[cyc]) begin
            chk("resp_data", resp_data, exp_rdata[cyc]);
            chk("resp_rd", 32'(resp_rd), 32'(exp_rrd[cyc]));
         end
         chk("addr_err", 32'(addr_err), 32'(exp_err[cyc]));
         if (exp_err[cyc]) chk("bad_vaddr", bad_vaddr, exp_bad[cyc]);
         if (!rst_n) begin
            chk("rst_mem_addr", mem_addr, 32'h0);
            chk("rst_resp_data", resp_data, 32'h0);
            chk("rst_resp_rd", 32'(resp_rd), 32'h0);
            chk("rst_bad_vaddr", bad_vaddr, 32'h0);
         end
      end
   end

   always @(posedge clk) begin
      if (cyc > 3000) begin
         $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
         $fatal(1, "watchdog");
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one load in the current cycle; returns in the cycle resp_valid is due.
   task automatic do_load(input logic [31:0] addr, input logic [2:0] sel, input logic [31:0] rt,
                          input logic [4:0] rd, input logic [31:0] m, input int k, input bit glitch);
      int t;
      t = cyc;
      req_valid = 1'b1; req_addr = addr; req_load_sel = sel; req_rt_data = rt; req_rd = rd;
      if (model_mis(addr, sel)) begin
         exp_err[t+1] = 1'b1;
         exp_bad[t+1] = addr;
      end else begin
         exp_rd_en[t+1] = 1'b1;
         exp_addr[t+1]  = {addr[31:2], 2'b00};
         for (int i = 1; i <= k + 1; i++) exp_ready[t+i] = 1'b0;
         exp_rv[t+2+k]    = 1'b1;
         exp_rdata[t+2+k] = model_load(sel, addr[1:0], m, rt);
         exp_rrd[t+2+k]   = rd;
      end
      step();
      req_valid = 1'b0;
      if (!model_mis(addr, sel)) begin
         if (glitch) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = 32'hDEADBEEF;
         end
         repeat (k) begin
            step();
            mem_rd_valid = 1'b0;
         end
         mem_rd_valid = 1'b1;
         mem_rd_data  = m;
         step();
         mem_rd_valid = 1'b0;
         mem_rd_data  = 32'hDEADBEEF;
      end
   endtask

   logic [31:0] pin_got, pin_m, pin_r;

   initial begin
      for (int i = 0; i < MAXC; i++) begin
         exp_ready[i] = 1'b1; exp_rd_en[i] = 1'b0; exp_addr[i] = 32'h0; exp_rv[i] = 1'b0;
         exp_rdata[i] = 32'h0; exp_rrd[i] = 5'd0; exp_err[i] = 1'b0; exp_bad[i] = 32'h0;
      end
      for (int i = 0; i < 3; i++) exp_ready[i] = 1'b0;

      pin_m = 32'h80FF7F01; pin_r = 32'h0;
      pin_got = model_load(3'd0, 2'd3, pin_m, pin_r); chk("pin_lb_a3", pin_got, 32'hFFFFFF80);
      pin_got = model_load(3'd1, 2'd3, pin_m, pin_r); chk("pin_lbu_a3", pin_got, 32'h00000080);
      pin_got = model_load(3'd2, 2'd2, pin_m, pin_r); chk("pin_lh_a2", pin_got, 32'hFFFF80FF);
      pin_got = model_load(3'd3, 2'd0, pin_m, pin_r); chk("pin_lhu_a0", pin_got, 32'h00007F01);
      pin_m = 32'hAABBCCDD; pin_r = 32'h11223344;
      pin_got = model_load(3'd5, 2'd1, pin_m, pin_r); chk("pin_lwl_a1", pin_got, 32'hBBCCDD44);
      pin_got = model_load(3'd5, 2'd3, pin_m, pin_r); chk("pin_lwl_a3", pin_got, 32'hDD223344);
      pin_got = model_load(3'd6, 2'd0, pin_m, pin_r); chk("pin_lwr_a0", pin_got, 32'h112233AA);
      pin_got = model_load(3'd6, 2'd1, pin_m, pin_r); chk("pin_lwr_a1", pin_got, 32'h1122AABB);
      pin_got = model_load(3'd6, 2'd2, pin_m, pin_r); chk("pin_lwr_a2", pin_got, 32'h11AABBCC);

      rst_n = 1'b0; flush = 1'b0; req_valid = 1'b1; req_addr = 32'h1000; req_load_sel = 3'd4;
      req_rt_data = 32'h0; req_rd = 5'd1; mem_rd_valid = 1'b0; mem_rd_data = 32'hDEADBEEF;
      step(); step(); step();
      rst_n = 1'b1; req_valid = 1'b0;

      for (int a = 0; a < 4; a++) begin
         do_load(32'h1000 + 32'(a), 3'd0, 32'h0, 5'(a + 1), 32'h80FF7F01, 1, 1'b0);
         do_load(32'h1000 + 32'(a), 3'd1, 32'h0, 5'(a + 5), 32'h80FF7F01, 1, 1'b0);
      end
      for (int a = 0; a < 4; a += 2) begin
         do_load(32'h1000 + 32'(a), 3'd2, 32'h0, 5'd10, 32'h80FF7F01, 1, 1'b0);
         do_load(32'h1000 + 32'(a), 3'd3, 32'h0, 5'd11, 32'h80FF7F01, 1, 1'b0);
      end
      do_load(32'h00002000, 3'd4, 32'h0, 5'd12, 32'h12345678, 2, 1'b1);
      do_load(32'hFFFF2004, 3'd7, 32'h0, 5'd13, 32'h9ABCDEF0, 3, 1'b0);
      for (int a = 0; a < 4; a++) begin
         do_load(32'h3000 + 32'(a), 3'd5, 32'h11223344, 5'(16 + a), 32'hAABBCCDD, 1 + (a % 2), 1'b0);
         do_load(32'h3000 + 32'(a), 3'd6, 32'h11223344, 5'(20 + a), 32'hAABBCCDD, 1 + (a % 2), 1'b0);
      end

      do_load(32'h00001002, 3'd4, 32'h0, 5'd2, 32'h0, 1, 1'b0);
      do_load(32'h00001001, 3'd2, 32'h0, 5'd3, 32'h0, 1, 1'b0);
      do_load(32'h00001002, 3'd2, 32'h0, 5'd4, 32'h80FF7F01, 1, 1'b0);
      do_load(32'h00001003, 3'd3, 32'h0, 5'd5, 32'h0, 1, 1'b0);
      do_load(32'h00001001, 3'd7, 32'h0, 5'd6, 32'h0, 1, 1'b0);
      step();

      // Flush in WAIT, read returns k=4 cycles after issue; next load waits out the drain.
      begin
         int t;
         t = cyc;
         req_valid = 1'b1; req_addr = 32'h4000; req_load_sel = 3'd4; req_rd = 5'd7;
         exp_rd_en[t+1] = 1'b1; exp_addr[t+1] = 32'h4000;
         for (int i = 1; i <= 5; i++) exp_ready[t+i] = 1'b0;
         step(); req_valid = 1'b0;
         step(); flush = 1'b1;
         step(); flush = 1'b0;
         req_valid = 1'b1; req_addr = 32'h5001; req_load_sel = 3'd0; req_rd = 5'd8;
         step();
         step(); mem_rd_valid = 1'b1; mem_rd_data = 32'h5555AAAA;
         step(); mem_rd_valid = 1'b0;
         do_load(32'h5001, 3'd0, 32'h0, 5'd8, 32'h0000C300, 1, 1'b0);
      end

      // Flush in ISSUE, then a stray read response while idle.
      begin
         int t;
         t = cyc;
         req_valid = 1'b1; req_addr = 32'h6000; req_load_sel = 3'd4; req_rd = 5'd9;
         exp_ready[t+1] = 1'b0;
         step(); req_valid = 1'b0; flush = 1'b1;
         step(); flush = 1'b0; mem_rd_valid = 1'b1; mem_rd_data = 32'h01010101;
         step(); mem_rd_valid = 1'b0;
      end

      // Flush coincident with the read response.
      begin
         int t;
         t = cyc;
         req_valid = 1'b1; req_addr = 32'h7000; req_load_sel = 3'd4; req_rd = 5'd14;
         exp_rd_en[t+1] = 1'b1; exp_addr[t+1] = 32'h7000;
         exp_ready[t+1] = 1'b0; exp_ready[t+2] = 1'b0;
         step(); req_valid = 1'b0;
         step(); flush = 1'b1; mem_rd_valid = 1'b1; mem_rd_data = 32'h77777777;
         step(); flush = 1'b0; mem_rd_valid = 1'b0;
         do_load(32'h7002, 3'd3, 32'h0, 5'd15, 32'hBEEF1234, 1, 1'b0);
      end

      // Flush in IDLE blocks acceptance.
      begin
         int t;
         t = cyc;
         req_valid = 1'b1; flush = 1'b1; req_addr = 32'h8000; req_load_sel = 3'd4;
         exp_ready[t] = 1'b0;
         step(); req_valid = 1'b0; flush = 1'b0;
      end
      do_load(32'h9003, 3'd6, 32'hCAFEF00D, 5'd31, 32'h0BADC0DE, 2, 1'b0);
      step(); step();

      done = 1'b1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
